// File: rtl/top_pkg.sv
// Shared types and constants for the binary_top multiple-of-3 classifier.
package top_pkg;
  localparam int CODE_W = 3;
  // bit i set => code i is a multiple of 3 (0, 3, 6)
  localparam logic [7:0] MUL3_MASK = 8'b0100_1001;
  typedef logic [CODE_W-1:0] code_t;
endpackage

// File: rtl/mul3_detect.sv
// Combinational multiple-of-3 detector for a 3-bit code; a lookup into MUL3_MASK.
module mul3_detect
  import top_pkg::*;
(
  input  code_t code,
  output logic  f
);
  assign f = MUL3_MASK[code];
endmodule

// File: rtl/binary_top.sv
// {A,B,C} multiple-of-3 classifier with registered code/decision, edge flag and hit counter.
// Optional per-code histogram counters when TOP_HIST_EN is defined.
module binary_top
  import top_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             A,
  input  logic             B,
  input  logic             C,
  output logic             F,
  output logic             f_q,
  output code_t            code_q,
  output logic             f_edge,
  output logic [CNT_W-1:0] hit_cnt
`ifdef TOP_HIST_EN
  ,
  input  code_t            hist_sel,
  output logic [CNT_W-1:0] hist_cnt
`endif
);
  code_t code;
  assign code = {A, B, C};

  mul3_detect u_det (
    .code (code),
    .f    (F)
  );

  // f_q resets to 1 so the reset state agrees with F(000)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      code_q  <= '0;
      f_q     <= 1'b1;
      f_edge  <= 1'b0;
      hit_cnt <= '0;
    end else begin
      code_q <= code;
      f_q    <= F;
      f_edge <= F ^ f_q;
      if (F && (hit_cnt != '1))
        hit_cnt <= hit_cnt + 1'b1;
    end
  end

`ifdef TOP_HIST_EN
  logic [7:0][CNT_W-1:0] hist_q;

  for (genvar i = 0; i < 8; i++) begin : g_hist
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        hist_q[i] <= '0;
      else if ((code == code_t'(i)) && (hist_q[i] != '1))
        hist_q[i] <= hist_q[i] + 1'b1;
    end
  end

  assign hist_cnt = hist_q[hist_sel];
`endif
endmodule

// File: tb/tb_binary_top.sv
// Randomized self-checking bench for binary_top; a CNT_W=8 and a CNT_W=2 instance share stimulus.
module tb_binary_top;
  logic clk = 1'b0;
  logic run = 1'b0;
  logic rst = 1'b0;
  logic A = 1'b0, B = 1'b0, C = 1'b0;
  logic F, f_q, f_edge, F_s, f_q_s, f_edge_s;
  logic [2:0] code_q, code_q_s;
  logic [7:0] hit_cnt;
  logic [1:0] hit_cnt_s;
  logic [2:0] hist_sel = 3'd0;
  logic [7:0] hist_cnt;
  logic [1:0] hist_cnt_s;

  int n_chk = 0;
  int n_fail = 0;

  // reference state
  int m_fq, m_edge, m_code, m_hit, m_hit_s;
  int m_hist[8];
  int m_hist_s[8];

  initial begin
    wait (run);
    forever #5 clk = ~clk;
  end

  binary_top #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
    .F(F), .f_q(f_q), .code_q(code_q), .f_edge(f_edge), .hit_cnt(hit_cnt)
`ifdef TOP_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(hist_cnt)
`endif
  );

  binary_top #(.CNT_W(2)) dut_s (
    .clk(clk), .rst(rst), .A(A), .B(B), .C(C),
    .F(F_s), .f_q(f_q_s), .code_q(code_q_s), .f_edge(f_edge_s), .hit_cnt(hit_cnt_s)
`ifdef TOP_HIST_EN
    , .hist_sel(hist_sel), .hist_cnt(hist_cnt_s)
`endif
  );

`ifndef TOP_HIST_EN
  assign hist_cnt   = '0;
  assign hist_cnt_s = '0;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_f(input int code);
    return (code % 3 == 0) ? 1 : 0;
  endfunction

  function automatic int sat_inc(input int v, input int maxv);
    return (v < maxv) ? v + 1 : v;
  endfunction

  task automatic set_code(input int code);
    {A, B, C} = code[2:0];
  endtask

  task automatic model_reset();
    m_fq = 1; m_edge = 0; m_code = 0; m_hit = 0; m_hit_s = 0;
    for (int i = 0; i < 8; i++) begin
      m_hist[i] = 0;
      m_hist_s[i] = 0;
    end
  endtask

  task automatic check_all(input string tag);
    int cur;
    cur = {29'd0, A, B, C};
    chk({tag, ".F"}, int'(F), ref_f(cur));
    chk({tag, ".F_s"}, int'(F_s), ref_f(cur));
    chk({tag, ".f_q"}, int'(f_q), m_fq);
    chk({tag, ".code_q"}, int'(code_q), m_code);
    chk({tag, ".f_edge"}, int'(f_edge), m_edge);
    chk({tag, ".hit_cnt"}, int'(hit_cnt), m_hit);
    chk({tag, ".hit_cnt_s"}, int'(hit_cnt_s), m_hit_s);
    chk({tag, ".f_edge_s"}, int'(f_edge_s), m_edge);
`ifdef TOP_HIST_EN
    chk({tag, ".hist"}, int'(hist_cnt), m_hist[hist_sel]);
    chk({tag, ".hist_s"}, int'(hist_cnt_s), m_hist_s[hist_sel]);
`endif
  endtask

  // Apply a code, clock once, advance the model, check 1 ns after the edge.
  task automatic step(input int code, input string tag);
    int f;
    set_code(code);
    @(posedge clk);
    f = ref_f(code);
    m_edge = (f != m_fq) ? 1 : 0;
    m_fq = f;
    m_code = code;
    if (f == 1) begin
      m_hit = sat_inc(m_hit, 255);
      m_hit_s = sat_inc(m_hit_s, 3);
    end
    m_hist[code] = sat_inc(m_hist[code], 255);
    m_hist_s[code] = sat_inc(m_hist_s[code], 3);
    #1;
    check_all(tag);
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_all("rst_async");
    rst = 1'b0;
  endtask

  initial begin
    int exp_f[8] = '{1, 0, 0, 1, 0, 0, 1, 0};
    int seq[4] = '{1, 3, 3, 4};
    int seq_edge[4] = '{1, 1, 0, 1};

    // combinational path with no clock
    set_code(0);
    #5;
    chk("F_noclk_000", int'(F), 1);
    for (int i = 0; i < 8; i++) begin
      set_code(i);
      #1;
      chk($sformatf("F_sweep_%0d", i), int'(F), exp_f[i]);
    end

    // async reset before the clock runs
    set_code(0);
    pulse_reset();
    run = 1'b1;

    // directed sequence after reset
    for (int i = 0; i < 4; i++) begin
      step(seq[i], "seq");
      chk($sformatf("seq_edge_%0d", i), int'(f_edge), seq_edge[i]);
    end
    chk("seq_hit", int'(hit_cnt), 2);

    // saturation of the 2-bit counter
    for (int i = 0; i < 6; i++) step(6, "sat");
    chk("sat_hit_s", int'(hit_cnt_s), 3);
    chk("sat_hit", int'(hit_cnt), 8);

    // reset between edges; F keeps tracking inputs while held
    set_code(3);
    #1 rst = 1'b1;
    #1;
    chk("midrst_hit_s", int'(hit_cnt_s), 0);
    chk("midrst_f_q", int'(f_q), 1);
    chk("midrst_code_q", int'(code_q), 0);
    chk("midrst_F3", int'(F), 1);
    set_code(5);
    #1;
    chk("midrst_F5", int'(F), 0);
    rst = 1'b0;
    model_reset();

`ifdef TOP_HIST_EN
    step(5, "hist");
    step(5, "hist");
    step(2, "hist");
    hist_sel = 3'd5;
    #1;
    chk("hist_sel5", int'(hist_cnt), 2);
    hist_sel = 3'd7;
    #1;
    chk("hist_sel7", int'(hist_cnt), 0);
`endif

    // random traffic with occasional async resets
    for (int i = 0; i < 300; i++) begin
      hist_sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 49) == 0) pulse_reset();
      step($urandom_range(0, 7), "rnd");
    end
    // bias towards multiples of 3 to reach 8-bit saturation
    for (int i = 0; i < 280; i++) begin
      hist_sel = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 3) == 0) ? $urandom_range(0, 7) : 3 * $urandom_range(0, 2), "rnd3");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
